// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes and FSM encodings for the sequential ALU.
// Imported by alu_seq and alu_mul_iter.
package alu_seq_pkg;

   localparam int DATA_WIDTH       = 32;
   localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;
   localparam int OPRN_WIDTH       = 6;
   localparam int OPRN_INDEX_LIMIT = OPRN_WIDTH - 1;
   localparam int MUL_CYCLES       = 32;
   localparam int CNT_WIDTH        = $clog2(MUL_CYCLES);
   localparam int SHAMT_WIDTH      = $clog2(DATA_WIDTH);

   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_ADD = 6'h20;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_SUB = 6'h22;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_MUL = 6'h2c;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_SHR = 6'h02;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_SHL = 6'h01;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_AND = 6'h24;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_OR  = 6'h25;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_NOR = 6'h27;
   localparam logic [OPRN_INDEX_LIMIT:0] OPRN_SLT = 6'h2a;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per clock, fixed latency.
// LOAD restarts it; LAST marks the edge that produces the final sum.
module alu_mul_iter
   import alu_seq_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      LOAD,
   input  logic [DATA_INDEX_LIMIT:0] A,
   input  logic [DATA_INDEX_LIMIT:0] B,
   output logic [DATA_INDEX_LIMIT:0] RESULT,
   output logic                      LAST
);

   logic [DATA_INDEX_LIMIT:0] acc;
   logic [DATA_INDEX_LIMIT:0] mcand;
   logic [DATA_INDEX_LIMIT:0] mplier;
   logic [CNT_WIDTH-1:0]      count;
   logic                      active;
   logic [DATA_INDEX_LIMIT:0] addend;

   // RESULT is the accumulator after the current iteration's add
   always_comb begin
      addend = mplier[0] ? mcand : '0;
      RESULT = acc + addend;
      LAST   = active && (count == CNT_WIDTH'(MUL_CYCLES - 1));
   end

   // Iteration registers: load operands, then add-and-shift each cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         active <= 1'b0;
      end else if (LOAD) begin
         acc    <= '0;
         mcand  <= A;
         mplier <= B;
         count  <= '0;
         active <= 1'b1;
      end else if (active) begin
         acc    <= RESULT;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (LAST)
            active <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshake ALU: single-cycle ops finish on the accept edge, MUL iterates.
// Results are held in output registers until the next completion.
module alu_seq
   import alu_seq_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   input  logic [DATA_INDEX_LIMIT:0] OP1,
   input  logic [DATA_INDEX_LIMIT:0] OP2,
   input  logic [OPRN_INDEX_LIMIT:0] OPRN,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [DATA_INDEX_LIMIT:0] OUT,
   output logic                      ZERO,
   output logic                      ERR
);

   state_t                    state;
   state_t                    next_state;
   logic                      accept;
   logic                      is_mul;
   logic                      mul_load;
   logic                      mul_last;
   logic [DATA_INDEX_LIMIT:0] mul_result;
   logic [DATA_INDEX_LIMIT:0] sc_out;
   logic                      sc_err;
   logic                      sh_big;
   logic [SHAMT_WIDTH-1:0]    shamt;

   alu_mul_iter u_mul (
      .CLK    (CLK),
      .RST    (RST),
      .LOAD   (mul_load),
      .A      (OP1),
      .B      (OP2),
      .RESULT (mul_result),
      .LAST   (mul_last)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Next state: MUL entered on accept, left on the last iteration
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (START && is_mul) next_state = ST_MUL;
         ST_MUL:  if (mul_last)        next_state = ST_IDLE;
         default:                      next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake decode and multiplier load
   always_comb begin
      is_mul   = (OPRN == OPRN_MUL);
      accept   = (state == ST_IDLE) && START;
      mul_load = accept && is_mul;
      BUSY     = (state == ST_MUL);
   end

   // Single-cycle datapath; shift amounts of 32 or more flush to zero
   always_comb begin
      shamt  = OP2[SHAMT_WIDTH-1:0];
      sh_big = |OP2[DATA_INDEX_LIMIT:SHAMT_WIDTH];
      sc_out = '0;
      sc_err = 1'b0;
      case (OPRN)
         OPRN_ADD: sc_out = OP1 + OP2;
         OPRN_SUB: sc_out = OP1 - OP2;
         OPRN_SHR: sc_out = sh_big ? '0 : (OP1 >> shamt);
         OPRN_SHL: sc_out = sh_big ? '0 : (OP1 << shamt);
         OPRN_AND: sc_out = OP1 & OP2;
         OPRN_OR:  sc_out = OP1 | OP2;
         OPRN_NOR: sc_out = ~(OP1 | OP2);
         OPRN_SLT: sc_out = {{DATA_INDEX_LIMIT{1'b0}}, (OP1 < OP2)};
         default:  sc_err = 1'b1;
      endcase
   end

   // Output registers: only completion edges update them
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT  <= '0;
         ZERO <= 1'b1;
         ERR  <= 1'b0;
         DONE <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (accept && !is_mul) begin
            OUT  <= sc_out;
            ZERO <= (sc_out == '0);
            ERR  <= sc_err;
            DONE <= 1'b1;
         end else if (mul_last) begin
            OUT  <= mul_result;
            ZERO <= (mul_result == '0);
            ERR  <= 1'b0;
            DONE <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [5:0]  oprn;
   logic        busy;
   logic        done;
   logic [31:0] out;
   logic        zero;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   alu_seq dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .OP1   (op1),
      .OP2   (op2),
      .OPRN  (oprn),
      .BUSY  (busy),
      .DONE  (done),
      .OUT   (out),
      .ZERO  (zero),
      .ERR   (err)
   );

   always #5 clk = ~clk;

   // Reference: {err, result} straight from the opcode table
   function automatic logic [32:0] model(input logic [5:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] r;
      logic        e;
      p = 64'(a) * 64'(b);
      r = 32'd0;
      e = 1'b0;
      case (op)
         6'h20: r = a + b;
         6'h22: r = a - b;
         6'h2c: r = p[31:0];
         6'h02: r = (b >= 32) ? 32'd0 : (a >> b);
         6'h01: r = (b >= 32) ? 32'd0 : (a << b);
         6'h24: r = a & b;
         6'h25: r = a | b;
         6'h27: r = ~(a | b);
         6'h2a: r = (a < b) ? 32'd1 : 32'd0;
         default: e = 1'b1;
      endcase
      return {e, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait (bounded) for DONE, check latency and results
   task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
      logic [32:0] e;
      logic [31:0] prev;
      int          k;
      int          bz;
      int          chg;
      int          lat;
      e   = model(op, a, b);
      lat = (op == 6'h2c) ? 32 : 0;
      @(negedge clk);
      prev  = out;
      start = 1'b1;
      oprn  = op;
      op1   = a;
      op2   = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      oprn  = 6'h20;
      op1   = $urandom;
      op2   = $urandom;
      k   = 0;
      bz  = 0;
      chg = 0;
      @(negedge clk);
      while (!done && k < 40) begin
         if (busy) bz++;
         if (out !== prev) chg++;
         k++;
         @(negedge clk);
      end
      chk({tag, "_lat"}, k, lat);
      chk({tag, "_busycyc"}, bz, lat);
      chk({tag, "_hold"}, chg, 0);
      chk({tag, "_out"}, out, e[31:0]);
      chk({tag, "_zero"}, 32'(zero), 32'(e[31:0] == 32'd0));
      chk({tag, "_err"}, 32'(err), 32'(e[32]));
      chk({tag, "_busy0"}, 32'(busy), 0);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 0);
   endtask

   logic [5:0]  b2b_op [6];
   logic [31:0] b2b_a  [6];
   logic [31:0] b2b_b  [6];
   logic [5:0]  pool   [11];

   initial begin
      logic [32:0] e;
      int          nd;
      logic [31:0] seen;
      logic [5:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      rst   = 1'b1;
      start = 1'b0;
      op1   = '0;
      op2   = '0;
      oprn  = '0;
      @(negedge clk);
      chk("rst_out", out, 0);
      chk("rst_zero", 32'(zero), 1);
      chk("rst_err", 32'(err), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;

      run_op(6'h20, 32'd15, 32'd3, "add15_3");

      // Back-to-back single-cycle ops, START high every cycle
      b2b_op = '{6'h22, 6'h02, 6'h01, 6'h27, 6'h2a, 6'h02};
      b2b_a  = '{32'd5, 32'd4, 32'd3, 32'd6, 32'd5, 32'd8};
      b2b_b  = '{32'd5, 32'd3, 32'd2, 32'd9, 32'd10, 32'd40};
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = model(b2b_op[i-1], b2b_a[i-1], b2b_b[i-1]);
            chk($sformatf("b2b%0d_done", i-1), 32'(done), 1);
            chk($sformatf("b2b%0d_out", i-1), out, e[31:0]);
            chk($sformatf("b2b%0d_zero", i-1), 32'(zero),
                32'(e[31:0] == 32'd0));
         end
         if (i < 6) begin
            start = 1'b1;
            oprn  = b2b_op[i];
            op1   = b2b_a[i];
            op2   = b2b_b[i];
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b_end_done", 32'(done), 0);

      run_op(6'h2c, 32'd2, 32'd7, "mul2_7");
      run_op(6'h2c, 32'hFFFF_FFFF, 32'd2, "mulff_2");
      run_op(6'h2c, 32'd0, 32'd3, "mul0_3");

      // MUL 3*5 with START pulses and operand churn while busy
      @(negedge clk);
      start = 1'b1;
      oprn  = 6'h2c;
      op1   = 32'd3;
      op2   = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      nd    = 0;
      seen  = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            seen = out;
         end
         if (c == 4 || c == 9 || c == 20) begin
            start = 1'b1;
            oprn  = 6'h20;
            op1   = $urandom;
            op2   = $urandom;
         end else begin
            start = 1'b0;
         end
      end
      chk("mulign_ndone", nd, 1);
      chk("mulign_out", seen, 32'd15);

      // Reset in the middle of MUL 9*9
      @(negedge clk);
      start = 1'b1;
      oprn  = 6'h2c;
      op1   = 32'd9;
      op2   = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_out", out, 0);
      chk("mrst_zero", 32'(zero), 1);
      chk("mrst_err", 32'(err), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      nd  = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("mrst_nodone", nd, 0);
      run_op(6'h20, 32'd1, 32'd0, "add1_0");

      run_op(6'h3f, 32'd7, 32'd7, "unk3f");
      run_op(6'h24, 32'd1, 32'd2, "and1_2");

      // Randomized ops, including unknown opcodes and large shifts
      pool = '{6'h20, 6'h22, 6'h2c, 6'h02, 6'h01, 6'h24,
               6'h25, 6'h27, 6'h2a, 6'h3f, 6'h10};
      for (int i = 0; i < 30; i++) begin
         rop = pool[$urandom_range(0, 10)];
         ra  = $urandom;
         rb  = $urandom;
         if ((rop == 6'h01 || rop == 6'h02) && $urandom_range(0, 3) != 0)
            rb = 32'($urandom_range(0, 40));
         if ($urandom_range(0, 7) == 0)
            rb = ra;
         run_op(rop, ra, rb, $sformatf("rnd%0d_op%0h", i, rop));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, handshake-driven ALU responder. It accepts one operation request (OP1, OP2, OPRN) per START and returns OUT, ZERO and ERR with a DONE pulse.
- Single-cycle operations complete in 1 cycle. MUL is an iterative shift-add over 32 cycles.
- Sits between the control unit / bench initiator and the datapath. It replaces the combinational ALU wherever a registered, multi-cycle result path is needed.

Parameters:
- DATA_WIDTH, 32, operand/result width (from `DATA_WIDTH).
- OPRN_WIDTH, 6, opcode width (from `ALU_OPRN_WIDTH).
- MUL_CYCLES, 32, shift-add iterations; must equal DATA_WIDTH.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request valid; sampled only in IDLE.
- OP1  in  DATA_WIDTH  operand 1.
- OP2  in  DATA_WIDTH  operand 2 / shift amount.
- OPRN  in  OPRN_WIDTH  operation code.
- BUSY  out  1  high while a MUL is iterating.
- DONE  out  1  one-cycle pulse; OUT, ZERO and ERR are valid.
- OUT  out  DATA_WIDTH  registered result; held until the next completion.
- ZERO  out  1  registered; equals (OUT == 0).
- ERR  out  1  registered; unknown opcode in the last completed op.

Behaviour:
- Reset values (async, immediate on RST high): state=IDLE, OUT=0, ZERO=1, ERR=0, DONE=0, BUSY=0, counter=0, accumulator=0.
- States:
  - IDLE: accepts START.
  - MUL: iterates.
- Accept rule: START=1 at a rising edge N in IDLE latches OP1, OP2 and OPRN. Input changes after edge N have no effect.
- START while in MUL: ignored, not queued.
- Single-cycle ops (result registered at edge N; DONE=1 in the cycle after N; state stays IDLE):
  - 0x20 ADD: OP1+OP2, mod 2^32.
  - 0x22 SUB: OP1-OP2, mod 2^32.
  - 0x02 SHR logical: OP1>>OP2. Full 32-bit OP2; any OP2>=32 gives 0.
  - 0x01 SHL: OP1<<OP2. Same amount rule as SHR.
  - 0x24 AND.
  - 0x25 OR.
  - 0x27 NOR: ~(OP1|OP2).
  - 0x2a SLT: unsigned compare, OUT = (OP1<OP2) ? 1 : 0.
- Unknown opcode: completes like a single-cycle op with OUT=0, ZERO=1, ERR=1.
- ERR=0 on every valid completion.
- MUL (0x2c), lower 32 bits of OP1*OP2:
  - Edge N: state→MUL, BUSY=1, acc=0, count=0.
  - Each edge in MUL: if multiplier bit0=1 then acc += multiplicand. Then multiplicand<<=1, multiplier>>=1, count++.
  - At the edge where count==31 (edge N+32): OUT=final acc, ZERO and ERR updated, DONE=1 in the next cycle, BUSY=0, state→IDLE.
  - Latency is fixed at 32 cycles regardless of operand values; there is no early exit.
- DONE is a registered pulse exactly 1 cycle wide.
- Back-to-back: the state is IDLE while DONE is high, so a START in that cycle is accepted. This gives continuous single-cycle throughput of 1 op/cycle.
- OUT, ZERO and ERR change only on completion edges or reset. They never show intermediate MUL values.
- RST mid-MUL: aborts immediately to the reset values. No DONE for the aborted op.
- START with X/Z on OPRN: treated as an unknown opcode, ERR=1.

Decomposition:
- Shared definition file (prj_definition): `DATA_WIDTH, `DATA_INDEX_LIMIT, `ALU_OPRN_WIDTH, `ALU_OPRN_INDEX_LIMIT, plus named opcode constants:
  - `ALU_OPRN_ADD, `ALU_OPRN_SUB, `ALU_OPRN_MUL
  - `ALU_OPRN_SHR, `ALU_OPRN_SHL
  - `ALU_OPRN_AND, `ALU_OPRN_OR, `ALU_OPRN_NOR, `ALU_OPRN_SLT
- Add the state encodings and `MUL_CYCLES there as well.
- One sub-module: alu_mul_iter. It owns the shift-add registers and counter, with ports CLK, RST, LOAD, A, B, RESULT, LAST.
- Top-level alu_seq holds the FSM, the single-cycle datapath and the output registers.

Test Plan:
- Reset: assert RST mid-stream, then release → OUT=0, ZERO=1, ERR=0, DONE=0, BUSY=0. Then ADD 15+3 → DONE one cycle later, OUT=18, ZERO=0.
- Single ops back-to-back, START high every cycle:
  - SUB 5-5 → OUT=0, ZERO=1.
  - SHR 4>>3 → 0.
  - SHL 3<<2 → 12.
  - NOR 6,9 → 0xFFFFFFF0.
  - SLT 5<10 → 1.
  - SHR 8>>40 → 0.
  - Expect 1 DONE per cycle with in-order results.
- MUL 2*7 → BUSY high for 32 cycles, DONE at accept+32 cycles, OUT=14. Also MUL 0xFFFFFFFF*2 → 0xFFFFFFFE. Also MUL 0*3 → 0 with ZERO=1 after the same latency.
- START pulsed and operands changed while BUSY during MUL 3*5 → ignored; OUT=15, exactly one DONE.
- RST asserted at cycle 10 of MUL 9*9 → immediate reset values, no DONE. A following ADD 1+0 → OUT=1.
- Unknown opcode 0x3f with OP1=7, OP2=7 → DONE after 1 cycle, OUT=0, ZERO=1, ERR=1. A following valid AND 1&2 → OUT=0, ERR=0.
